// File: rtl/shifter_pkg.sv
// Shared mode and FSM-state encodings for the iterative shifter.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shifter_step.sv
// One combinational shift step of 0..STEP bits in any of the four modes.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] sra_wide;
  logic [2*WIDTH-1:0] rol_wide;

  always_comb begin
    // Double-width views avoid a WIDTH-amount subtraction for fill and wrap bits.
    sra_wide = {{WIDTH{sign}}, data} >> amount;
    rol_wide = {data, data} << amount;
    result   = data;
    case (mode)
      MODE_SLL: result = data << amount;
      MODE_SRL: result = data >> amount;
      MODE_SRA: result = sra_wide[WIDTH-1:0];
      MODE_ROL: result = rol_wide[2*WIDTH-1:WIDTH];
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by up to STEP bits per cycle with
// valid/ready handshakes and a single outstanding operation.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int AMT_W = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;

  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] step_amt_s;
  logic [WIDTH-1:0]   step_res;

  // k = min(remaining, STEP); STEP may exceed what SHAMT_W can hold.
  always_comb begin
    if (32'(rem_q) < STEP) step_amt = AMT_W'(rem_q);
    else                   step_amt = AMT_W'(STEP);
    step_amt_s = SHAMT_W'(step_amt);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .data  (work_q),
    .amount(step_amt),
    .mode  (mode_q),
    .sign  (sign_q),
    .result(step_res)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    out_data_d = out_data_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    sign_d     = sign_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          mode_d = in_mode;
          sign_d = in_data[WIDTH-1];
          rem_d  = in_shamt;
          if (in_shamt == '0) begin
            out_data_d = in_data;
            state_d    = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_res;
        rem_d  = rem_q - step_amt_s;
        if (rem_q == step_amt_s) begin
          out_data_d = step_res;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      out_data_q <= '0;
      rem_q      <= '0;
      mode_q     <= MODE_SLL;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      out_data_q <= out_data_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      sign_q     <= sign_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and random checks of iter_shifter at STEP=4 (main), STEP=1 and STEP=32.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [31:0] out_data_v [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]));

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]));

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) dut_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_data(out_data_v[2]));

  function automatic int step_of(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(logic [31:0] d, int s, logic [1:0] m);
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return (d << s) | (d >> (32 - s));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one request on the main instance from IDLE; returns result and
  // edges from accept to out_valid (accept edge counted). Consumes if out_ready.
  task automatic run_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         output logic [31:0] res, output int lat);
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_v[0] && lat < 100) begin
      tick();
      lat++;
    end
    res = out_data_v[0];
    if (out_ready) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid_v !== 3'b000) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=000", out_valid_v);
    end
    checks++;
    if (in_ready_v !== 3'b111) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=111", in_ready_v);
    end
    checks++;
    if (out_data_v[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=00000000", out_data_v[0]);
    end
  endtask

  task automatic test_branch_offset();
    logic [31:0] res;
    int lat;
    out_ready = 1'b1;
    run_req(32'h0000_0123, 5'd2, 2'b00, res, lat);
    checks++;
    if (res !== 32'h0000_048C) begin
      failures++;
      $display("FAIL branch_data got=%h exp=0000048c", res);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL branch_latency got=%0d exp=2", lat);
    end
  endtask

  task automatic test_sra_srl();
    logic [31:0] res;
    int lat;
    out_ready = 1'b1;
    run_req(32'h8000_00F0, 5'd31, 2'b10, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sra_data got=%h exp=ffffffff", res);
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL sra_latency got=%0d exp=9", lat);
    end
    run_req(32'h8000_00F0, 5'd31, 2'b01, res, lat);
    checks++;
    if (res !== 32'h0000_0001) begin
      failures++;
      $display("FAIL srl_data got=%h exp=00000001", res);
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL srl_latency got=%0d exp=9", lat);
    end
  endtask

  task automatic test_rotate_zero();
    logic [31:0] res;
    logic [31:0] d;
    int lat;
    out_ready = 1'b1;
    run_req(32'hF000_000F, 5'd4, 2'b11, res, lat);
    checks++;
    if (res !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL rol_data got=%h exp=000000ff", res);
    end
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL rol_latency got=%0d exp=2", lat);
    end
    for (int m = 0; m < 4; m++) begin
      d = 32'hA5A5_0F0F ^ (32'h1111_1111 * m);
      run_req(d, 5'd0, 2'(m), res, lat);
      checks++;
      if (res !== d) begin
        failures++;
        $display("FAIL zero_shift_data mode=%0d got=%h exp=%h", m, res, d);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL zero_shift_latency mode=%0d got=%0d exp=1", m, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    in_data   = 32'h1234_5678;
    in_shamt  = 5'd8;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid_v[0] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL bp_latency got=%0d exp=3", n);
    end
    // A competing request while the result is held must be ignored.
    in_data  = 32'hDEAD_BEEF;
    in_shamt = 5'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid_v[0] !== 1'b1 || out_data_v[0] !== 32'h3456_7800 || in_ready_v[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%h in_ready=%b exp valid=1 data=34567800 in_ready=0",
                 c, out_valid_v[0], out_data_v[0], in_ready_v[0]);
      end
    end
    in_data   = 32'h0000_00FF;
    in_shamt  = 5'd4;
    in_mode   = 2'b11;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b valid=%b exp in_ready=1 valid=0",
               in_ready_v[0], out_valid_v[0]);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_accept got in_ready=%b exp=0", in_ready_v[0]);
    end
    n = 1;
    while (!out_valid_v[0] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (out_data_v[0] !== 32'h0000_0FF0 || n !== 2) begin
      failures++;
      $display("FAIL bp_next_result got data=%h lat=%0d exp data=00000ff0 lat=2", out_data_v[0], n);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    int lat;
    out_ready = 1'b1;
    in_data   = 32'h0000_0001;
    in_shamt  = 5'd20;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid_v[0] !== 1'b0 || out_data_v[0] !== 32'h0 || in_ready_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got valid=%b data=%h in_ready=%b exp valid=0 data=00000000 in_ready=1",
               out_valid_v[0], out_data_v[0], in_ready_v[0]);
    end
    run_req(32'h0000_0001, 5'd20, 2'b00, res, lat);
    checks++;
    if (res !== 32'h0010_0000 || lat !== 6) begin
      failures++;
      $display("FAIL mid_reset_retry got data=%h lat=%0d exp data=00100000 lat=6", res, lat);
    end
  endtask

  task automatic test_random_sweep();
    logic [31:0] d;
    logic [31:0] exp_v;
    int s;
    int cyc;
    logic [2:0] seen;
    logic [2:0] done;
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      checks++;
      if (in_ready_v !== 3'b111) begin
        failures++;
        $display("FAIL sweep_idle t=%0d got in_ready=%b exp=111", t, in_ready_v);
      end
      d        = $urandom;
      s        = $urandom_range(0, 31);
      in_data  = d;
      in_shamt = 5'(s);
      in_mode  = 2'($urandom_range(0, 3));
      exp_v    = ref_shift(d, s, in_mode);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc  = 1;
      seen = '0;
      done = '0;
      while (done != 3'b111 && cyc < 200) begin
        for (int i = 0; i < 3; i++) begin
          if (out_valid_v[i] && !seen[i]) begin
            seen[i] = 1'b1;
            checks++;
            if (cyc !== 1 + (s + step_of(i) - 1) / step_of(i)) begin
              failures++;
              $display("FAIL sweep_latency step=%0d shamt=%0d got=%0d exp=%0d",
                       step_of(i), s, cyc, 1 + (s + step_of(i) - 1) / step_of(i));
            end
            checks++;
            if (out_data_v[i] !== exp_v) begin
              failures++;
              $display("FAIL sweep_data step=%0d d=%h shamt=%0d mode=%0d got=%h exp=%h",
                       step_of(i), d, s, in_mode, out_data_v[i], exp_v);
            end
          end
        end
        out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++)
          if (out_valid_v[i] && out_ready) done[i] = 1'b1;
        tick();
        cyc++;
      end
      if (done != 3'b111) begin
        checks++;
        failures++;
        $display("FAIL sweep_timeout t=%0d done=%b exp=111", t, done);
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch_offset();
    test_sra_srl();
    test_rotate_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
